// File: rtl/cordic_rot_pkg.sv
// Shared types and constants for the rotation-mode CORDIC (angle -> cos/sin).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cordic_rot_pkg;

  localparam int ANGLEW  = 16;
  localparam int ANGFRAC = 7;

  // Signed degrees, Q9.7 (LSB = 1/128 degree).
  typedef logic signed [ANGLEW-1:0] angle_t;

  localparam angle_t DEG90 = angle_t'(90 << ANGFRAC);

  // Gain of the full micro-rotation chain is 1/CORDIC_K; the start vector is pre-scaled by it.
  localparam real CORDIC_K = 0.607253;

  // atan(2**-i) in degrees, Q9.7.
  localparam angle_t ATAN [0:13] = '{
    16'sd5760, 16'sd3400, 16'sd1797, 16'sd912, 16'sd458, 16'sd229, 16'sd115,
    16'sd57,   16'sd29,   16'sd14,   16'sd7,   16'sd4,   16'sd2,   16'sd1
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_ROUND = 2'd2
  } state_t;

  // Table lookup that stays defined for counter values beyond the table depth.
  function automatic angle_t atan_lut(input logic [3:0] i);
    atan_lut = (i <= 4'd13) ? ATAN[i] : '0;
  endfunction

endpackage

// File: rtl/cordic_rot_if.sv
// Request/result bundle between a CORDIC rotation client and the engine.
// Latency: n/a (wiring only).
// Backpressure: none; i_start is ignored by the engine while o_busy is high.
interface cordic_rot_if #(
  parameter int OUTW = 12
);
  import cordic_rot_pkg::*;

  logic                   i_start;
  angle_t                 i_angle;
  logic                   o_busy;
  logic                   o_valid;
  logic signed [OUTW-1:0] o_cos;
  logic signed [OUTW-1:0] o_sin;
`ifdef CORDIC_ROT_RESID_EN
  angle_t                 o_resid;

  modport master (output i_start, i_angle, input o_busy, o_valid, o_cos, o_sin, o_resid);
  modport slave  (input i_start, i_angle, output o_busy, o_valid, o_cos, o_sin, o_resid);
`else
  modport master (output i_start, i_angle, input o_busy, o_valid, o_cos, o_sin);
  modport slave  (input i_start, i_angle, output o_busy, o_valid, o_cos, o_sin);
`endif

endinterface

// File: rtl/cordic_rot_step.sv
// One CORDIC micro-rotation: rotates (x,y) by -/+atan(2**-i) toward driving z to zero.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module cordic_rot_step
  import cordic_rot_pkg::*;
#(
  parameter int W = 18
) (
  input  logic signed [W-1:0] i_x,
  input  logic signed [W-1:0] i_y,
  input  angle_t              i_z,
  input  logic [3:0]          i_iter,
  input  angle_t              i_atan,
  output logic signed [W-1:0] o_x,
  output logic signed [W-1:0] o_y,
  output angle_t              o_z
);

  logic signed [W-1:0] w_xs;
  logic signed [W-1:0] w_ys;

  // Both shifts use the pre-step values so x and y update simultaneously.
  assign w_xs = i_x >>> i_iter;
  assign w_ys = i_y >>> i_iter;

  // Rotate in the direction that reduces the remaining angle.
  always_comb begin
    o_x = i_x;
    o_y = i_y;
    o_z = i_z;
    if (!i_z[ANGLEW-1]) begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - i_atan;
    end else begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + i_atan;
    end
  end

endmodule

// File: rtl/cordic_rot.sv
// Iterative rotation-mode CORDIC: angle (deg, Q9.7) -> cos/sin (Q2.OUTW-2); residual port with CORDIC_ROT_RESID_EN.
// Latency: start sampled at edge 0, o_valid pulses in the cycle after edge NUMITER+1.
// Backpressure: none; i_start is dropped while busy, accepted again in the o_valid cycle.
module cordic_rot
  import cordic_rot_pkg::*;
#(
  parameter int OUTW    = 12,
  parameter int GUARD   = 6,
  parameter int NUMITER = 14
) (
  input logic        i_clk,
  input logic        i_rst,
  cordic_rot_if.slave bus
);

  localparam int W      = OUTW + GUARD;
  localparam int K0_I   = $rtoi(CORDIC_K * (2.0 ** (OUTW - 2 + GUARD)) + 0.5);
  localparam int ONE_I  = 2 ** (OUTW - 2);
  localparam int HALF_I = 2 ** (GUARD - 1);

  localparam logic signed [W-1:0]    K0      = K0_I[W-1:0];
  localparam logic signed [W-1:0]    NK0     = -K0;
  localparam logic signed [W:0]      HALF    = HALF_I[W:0];
  localparam logic signed [W:0]      ONE_W   = ONE_I[W:0];
  localparam logic signed [W:0]      NONE_W  = -ONE_W;
  localparam logic signed [OUTW-1:0] ONE_O   = ONE_I[OUTW-1:0];
  localparam logic signed [OUTW-1:0] NONE_O  = -ONE_O;
  localparam angle_t                 NDEG90  = -DEG90;
  localparam logic [3:0]             LAST    = 4'(NUMITER - 1);

  state_t                 r_state;
  logic [3:0]             r_iter;
  logic signed [W-1:0]    r_x;
  logic signed [W-1:0]    r_y;
  angle_t                 r_z;
  logic                   r_busy;
  logic                   r_valid;
  logic signed [OUTW-1:0] r_cos;
  logic signed [OUTW-1:0] r_sin;
`ifdef CORDIC_ROT_RESID_EN
  angle_t                 r_resid;
`endif

  logic signed [W-1:0] w_x_nxt;
  logic signed [W-1:0] w_y_nxt;
  angle_t              w_z_nxt;

  // Drop the guard bits with round-half-up, then clamp to +/-1.0.
  function automatic logic signed [OUTW-1:0] rnd_sat(input logic signed [W-1:0] v);
    logic signed [W:0] t;
    t = ($signed({v[W-1], v}) + HALF) >>> GUARD;
    if (t > ONE_W)
      rnd_sat = ONE_O;
    else if (t < NONE_W)
      rnd_sat = NONE_O;
    else
      rnd_sat = t[OUTW-1:0];
  endfunction

  cordic_rot_step #(.W(W)) u_step (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_z    (r_z),
    .i_iter (r_iter),
    .i_atan (atan_lut(r_iter)),
    .o_x    (w_x_nxt),
    .o_y    (w_y_nxt),
    .o_z    (w_z_nxt)
  );

  // Control FSM plus datapath registers; quadrant pre-rotation keeps z inside the convergence range.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_iter  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_cos   <= '0;
      r_sin   <= '0;
`ifdef CORDIC_ROT_RESID_EN
      r_resid <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_busy  <= 1'b1;
            r_iter  <= '0;
            r_state <= ST_ITER;
            if (bus.i_angle > DEG90) begin
              r_x <= '0;
              r_y <= K0;
              r_z <= bus.i_angle - DEG90;
            end else if (bus.i_angle < NDEG90) begin
              r_x <= '0;
              r_y <= NK0;
              r_z <= bus.i_angle + DEG90;
            end else begin
              r_x <= K0;
              r_y <= '0;
              r_z <= bus.i_angle;
            end
          end
        end
        ST_ITER: begin
          r_x    <= w_x_nxt;
          r_y    <= w_y_nxt;
          r_z    <= w_z_nxt;
          r_iter <= r_iter + 4'd1;
          if (r_iter == LAST)
            r_state <= ST_ROUND;
        end
        ST_ROUND: begin
          r_cos   <= rnd_sat(r_x);
          r_sin   <= rnd_sat(r_y);
`ifdef CORDIC_ROT_RESID_EN
          r_resid <= r_z;
`endif
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_busy  = r_busy;
  assign bus.o_valid = r_valid;
  assign bus.o_cos   = r_cos;
  assign bus.o_sin   = r_sin;
`ifdef CORDIC_ROT_RESID_EN
  assign bus.o_resid = r_resid;
`endif

endmodule

// File: tb/tb_cordic_rot.sv
// Self-checking bench for cordic_rot: directed angles, busy-drop, mid-run reset, sweep and random angles.
// Latency: checks o_valid arrives NUMITER+2 edges after start.
// Backpressure: exercises ignored starts while busy and back-to-back starts in the o_valid cycle.
module tb_cordic_rot;
  import cordic_rot_pkg::*;

  localparam int OUTW    = 12;
  localparam int GUARD   = 6;
  localparam int NUMITER = 14;
  localparam int TOL     = 3;
  localparam int LAT     = NUMITER + 2;
  localparam int BUDGET  = 40;
  localparam real PI     = 3.14159265358979;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cordic_rot_if #(.OUTW(OUTW)) u_if ();

  cordic_rot #(.OUTW(OUTW), .GUARD(GUARD), .NUMITER(NUMITER)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if.slave)
  );

  task automatic chk_eq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp);
    int d;
    d = (obs > exp) ? obs - exp : exp - obs;
    checks++;
    assert ((d <= TOL) === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, TOL);
    end
  endtask

  // Reference: ideal trig scaled to 1.0 = 2**(OUTW-2), rounded to nearest.
  function automatic int ref_trig(input int a, input bit want_sin);
    real rad;
    real v;
    rad = (real'(a) / 128.0) * PI / 180.0;
    v   = want_sin ? $sin(rad) : $cos(rad);
    return int'($floor(v * real'(2 ** (OUTW - 2)) + 0.5));
  endfunction

  // Called at a negedge: request angle a, return at the negedge where o_valid is seen.
  task automatic run_op(input int a, output int lat);
    u_if.i_start = 1'b1;
    u_if.i_angle = 16'(a);
    lat = 0;
    do begin
      @(negedge clk);
      u_if.i_start = 1'b0;
      lat++;
      if (lat == 1) chk_eq("busy_after_accept", int'(u_if.o_busy), 1);
    end while (!u_if.o_valid && lat < BUDGET);
    chk_eq("latency", lat, LAT);
    chk_eq("busy_at_valid", int'(u_if.o_busy), 0);
  endtask

  task automatic chk_model(input string tag, input int a);
    chk_near({tag, "_cos"}, int'(u_if.o_cos), ref_trig(a, 1'b0));
    chk_near({tag, "_sin"}, int'(u_if.o_sin), ref_trig(a, 1'b1));
`ifdef CORDIC_ROT_RESID_EN
    chk_eq({tag, "_resid_ok"}, int'(u_if.o_resid >= -16'sd2 && u_if.o_resid <= 16'sd2), 1);
`endif
  endtask

  int dir_ang [6] = '{0, 11520, -11520, 3840, -17280, 23040};
  int dir_cos [6] = '{1024, 0, 0, 887, -724, -1024};
  int dir_sin [6] = '{0, 1024, -1024, 512, -724, 0};

  initial begin
    int lat;
    int nv;
    int a;

    rst          = 1'b1;
    u_if.i_start = 1'b0;
    u_if.i_angle = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_busy",  int'(u_if.o_busy),  0);
    chk_eq("rst_valid", int'(u_if.o_valid), 0);
    chk_eq("rst_cos",   int'(u_if.o_cos),   0);
    chk_eq("rst_sin",   int'(u_if.o_sin),   0);
`ifdef CORDIC_ROT_RESID_EN
    chk_eq("rst_resid", int'(u_if.o_resid), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Directed angles from the datasheet table, issued back-to-back.
    foreach (dir_ang[k]) begin
      run_op(dir_ang[k], lat);
      chk_near($sformatf("dir%0d_cos", k), int'(u_if.o_cos), dir_cos[k]);
      chk_near($sformatf("dir%0d_sin", k), int'(u_if.o_sin), dir_sin[k]);
    end

    // Second start 3 cycles into a 30-degree run must be dropped.
    u_if.i_start = 1'b1;
    u_if.i_angle = 16'sd3840;
    nv = 0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      u_if.i_start = (k == 3);
      if (k == 3) u_if.i_angle = 16'sd7680;
      if (u_if.o_valid) begin
        nv++;
        if (nv == 1) begin
          chk_eq("drop_latency", k, LAT);
          chk_near("drop_cos", int'(u_if.o_cos), 887);
          chk_near("drop_sin", int'(u_if.o_sin), 512);
        end
      end
    end
    chk_eq("drop_single_valid", nv, 1);

    // Reset asserted across ITER step 5 aborts the run.
    u_if.i_start = 1'b1;
    u_if.i_angle = 16'sd3840;
    nv = 0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      u_if.i_start = 1'b0;
      if (k == 5) rst = 1'b1;
      if (k == 6) begin
        rst = 1'b0;
        chk_eq("abort_cos",  int'(u_if.o_cos),  0);
        chk_eq("abort_sin",  int'(u_if.o_sin),  0);
        chk_eq("abort_busy", int'(u_if.o_busy), 0);
      end
      if (u_if.o_valid) nv++;
    end
    chk_eq("abort_no_valid", nv, 0);
    run_op(3840, lat);
    chk_model("after_abort", 3840);

    // Full sweep, one degree per step, back-to-back.
    for (int d = -180; d <= 180; d++) begin
      run_op(d * 128, lat);
      chk_model($sformatf("sweep%0d", d), d * 128);
    end

    // Random legal angles at full Q9.7 resolution.
    for (int k = 0; k < 60; k++) begin
      a = int'($urandom_range(46080, 0)) - 23040;
      run_op(a, lat);
      chk_model($sformatf("rand_a%0d", a), a);
    end

    u_if.i_start = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
